// File: rtl/drop_controller_pkg.sv
// Shared Connect-4 constants, FSM state encoding and board type used by the
// drop controller, its landing-row finder and the interface.
package connect4_pkg;

  localparam int          ROWS         = 6;
  localparam int          COLS         = 7;
  localparam logic [2:0]  NO_TARGET    = 3'd7;
  localparam logic [2:0]  CURSOR_RESET = 3'd3;
  localparam logic [2:0]  COL_MAX      = 3'd6;
  localparam logic [5:0]  MAX_MOVES    = 6'd42;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FALL   = 2'd1,
    COMMIT = 2'd2,
    FULL   = 2'd3
  } state_t;

  typedef logic [ROWS-1:0][COLS-1:0] board_t;

  function automatic logic [COLS-1:0] col_onehot(input logic [2:0] col);
    logic [COLS-1:0] oh;
    oh = {COLS{1'b0}};
    for (int c = 0; c < COLS; c++) begin
      oh[c] = (col == 3'(c));
    end
    return oh;
  endfunction

endpackage

// File: rtl/drop_controller_if.sv
// Move-input and board/status bundle between the drop controller (slave)
// and its driver (master).
interface drop_controller_if;
  import connect4_pkg::*;

  logic       left;
  logic       right;
  logic       drop;
  logic       game_over;
  board_t     board0;
  board_t     board1;
  logic [6:0] ledPosition;
  logic       player;
  logic       falling;
  logic [2:0] fall_row;
  logic [2:0] fall_col;
  logic [5:0] move_count;
  logic       board_full;
  logic       drop_reject;
  logic       move_done;

  modport master (
    output left, right, drop, game_over,
    input  board0, board1, ledPosition, player, falling, fall_row,
    input  fall_col, move_count, board_full, drop_reject, move_done
  );

  modport slave (
    input  left, right, drop, game_over,
    output board0, board1, ledPosition, player, falling, fall_row,
    output fall_col, move_count, board_full, drop_reject, move_done
  );

endinterface

// File: rtl/drop_controller_compute_drop.sv
// Combinational landing-row finder: lowest empty row (highest index) of the
// selected column, or NO_TARGET when the column is full or out of range.
module computeDrop
  import connect4_pkg::*;
(
  input  board_t     board0,
  input  board_t     board1,
  input  logic [3:0] column,
  output logic [2:0] target
);

  // scan top to bottom so the deepest empty cell wins
  always_comb begin
    target = NO_TARGET;
    if (column < 4'd7) begin
      for (int r = 0; r < ROWS; r++) begin
        target = (board0[r][column[2:0]] | board1[r][column[2:0]]) ? target : 3'(r);
      end
    end else begin
      target = NO_TARGET;
    end
  end

endmodule

// File: rtl/drop_controller.sv
// Connect-4 move sequencer: cursor handling, animated piece fall with a
// one-cycle commit into the player's bitplane, and full-board lockout.
module drop_controller
  import connect4_pkg::*;
#(
  parameter int TICK_CYCLES = 5_000_000
) (
  input  logic             clk,
  input  logic             reset,
  drop_controller_if.slave bus
);

  localparam int            CW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);

  state_t        state_q;
  board_t        board0_q, board1_q;
  board_t        board0_d, board1_d;
  logic [2:0]    cursor_q, cursor_d;
  logic [6:0]    led_q;
  logic          player_q;
  logic          falling_q;
  logic [2:0]    fall_row_q;
  logic [2:0]    fall_col_q;
  logic [2:0]    target_q;
  logic [2:0]    drop_target_d;
  logic [5:0]    move_count_q, move_count_d;
  logic          board_full_q;
  logic          drop_reject_q;
  logic          move_done_q;
  logic [CW-1:0] tick_q;

  computeDrop u_compute_drop (
    .board0 (board0_q),
    .board1 (board1_q),
    .column ({1'b0, cursor_q}),
    .target (drop_target_d)
  );

  // saturating cursor move; simultaneous left+right cancels
  always_comb begin
    cursor_d = cursor_q;
    if (bus.left && !bus.right) begin
      cursor_d = (cursor_q == 3'd0) ? 3'd0 : cursor_q - 3'd1;
    end else if (bus.right && !bus.left) begin
      cursor_d = (cursor_q == COL_MAX) ? COL_MAX : cursor_q + 3'd1;
    end else begin
      cursor_d = cursor_q;
    end
  end

  // board contents after placing the falling piece
  always_comb begin
    board0_d     = board0_q;
    board1_d     = board1_q;
    move_count_d = move_count_q + 6'd1;
    if (player_q == 1'b0) begin
      board0_d[target_q][fall_col_q] = 1'b1;
    end else begin
      board1_d[target_q][fall_col_q] = 1'b1;
    end
  end

  // move sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      board0_q      <= '0;
      board1_q      <= '0;
      cursor_q      <= CURSOR_RESET;
      led_q         <= 7'b0001000;
      player_q      <= 1'b0;
      falling_q     <= 1'b0;
      fall_row_q    <= 3'd0;
      fall_col_q    <= CURSOR_RESET;
      target_q      <= 3'd0;
      move_count_q  <= 6'd0;
      board_full_q  <= 1'b0;
      drop_reject_q <= 1'b0;
      move_done_q   <= 1'b0;
      tick_q        <= '0;
    end else begin
      drop_reject_q <= 1'b0;
      move_done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!bus.game_over) begin
            if (bus.drop) begin
              if (drop_target_d == NO_TARGET) begin
                drop_reject_q <= 1'b1;
              end else begin
                fall_col_q <= cursor_q;
                target_q   <= drop_target_d;
                fall_row_q <= 3'd0;
                tick_q     <= '0;
                falling_q  <= 1'b1;
                state_q    <= FALL;
              end
            end else begin
              cursor_q <= cursor_d;
              led_q    <= col_onehot(cursor_d);
            end
          end
        end
        FALL: begin
          if (tick_q == TICK_LAST) begin
            tick_q <= '0;
            if (fall_row_q == target_q) begin
              falling_q <= 1'b0;
              state_q   <= COMMIT;
            end else begin
              fall_row_q <= fall_row_q + 3'd1;
            end
          end else begin
            tick_q <= tick_q + CW'(1);
          end
        end
        COMMIT: begin
          board0_q     <= board0_d;
          board1_q     <= board1_d;
          move_count_q <= move_count_d;
          player_q     <= ~player_q;
          move_done_q  <= 1'b1;
          if (move_count_d == MAX_MOVES) begin
            board_full_q <= 1'b1;
            state_q      <= FULL;
          end else begin
            state_q <= IDLE;
          end
        end
        FULL: begin
          board_full_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.board0      = board0_q;
  assign bus.board1      = board1_q;
  assign bus.ledPosition = led_q;
  assign bus.player      = player_q;
  assign bus.falling     = falling_q;
  assign bus.fall_row    = fall_row_q;
  assign bus.fall_col    = fall_col_q;
  assign bus.move_count  = move_count_q;
  assign bus.board_full  = board_full_q;
  assign bus.drop_reject = drop_reject_q;
  assign bus.move_done   = move_done_q;

endmodule
